// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline hazard controller: FSM states, forwarding
// selects and register-address constants.
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // MEM wins over WB because it holds the younger result; $zero never forwards.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  mem_we,
        input logic                  wb_we
    );
        if (mem_we && mem_rd != REG_ZERO && mem_rd == src) return FWD_MEM;
        if (wb_we && wb_rd != REG_ZERO && wb_rd == src)    return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/mips_fwd_unit.sv
// Combinational EX-stage operand forwarding selects for ALU inputs A (rs) and B (rt).
module mips_fwd_unit
    import mips_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    output fwd_sel_e              fwd_a,
    output fwd_sel_e              fwd_b
);

    assign fwd_a = fwd_pick(ex_rs, mem_rd, wb_rd, mem_reg_write, wb_reg_write);
    assign fwd_b = fwd_pick(ex_rt, mem_rd, wb_rd, mem_reg_write, wb_reg_write);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage MIPS pipe. Optional statistics
// counters are built when MIPS_HAZ_STATS_EN is defined.
module mips_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  ex_branch_taken,
    input  logic                  id_jump,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [1:0]            ctrl_state,
    output logic                  mem_timeout
`ifdef MIPS_HAZ_STATS_EN
   ,output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      memwait_cnt
`endif
);

    localparam int FCNT_W = 3;
    localparam int WCNT_W = 8;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    ctrl_state_e        state_q, state_d, ret_q, ret_d, eval_st;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_stall_c;
    logic               load_use, load_use_stall;
    fwd_sel_e           fwd_a_c, fwd_b_c;

    mips_fwd_unit u_fwd (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a_c),
        .fwd_b         (fwd_b_c)
    );

    assign load_use = ex_mem_read && ex_rd != REG_ZERO && (ex_rd == id_rs || ex_rd == id_rt);

    always_comb begin
        pc_write_c     = 1'b1;
        ifid_write_c   = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        pipe_stall_c   = 1'b0;
        load_use_stall = 1'b0;
        state_d        = state_q;
        ret_d          = ret_q;
        fcnt_d         = fcnt_q;
        wcnt_d         = wcnt_q;
        mem_timeout_d  = mem_timeout_q;
        // On the release cycle of MEM_WAIT the pipe behaves as the state it left.
        eval_st        = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (mem_busy) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            pipe_stall_c = 1'b1;
            // The entry cycle counts, so the flag registers at the end of the
            // MEM_TIMEOUT-th consecutive busy cycle.
            wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
            if (wcnt_d == WCNT_MAX) mem_timeout_d = 1'b1;
            if (state_q != MEM_WAIT) begin
                state_d = MEM_WAIT;
                ret_d   = state_q;
            end
        end else begin
            wcnt_d  = '0;
            state_d = eval_st;
            case (eval_st)
                FLUSH: begin
                    ifid_flush_c = 1'b1;
                    if (fcnt_q <= FCNT_W'(1)) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
                default: begin
                    if (ex_branch_taken) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (load_use) begin
                        load_use_stall = 1'b1;
                    end else if (id_jump) begin
                        ifid_flush_c = 1'b1;
                    end
                end
            endcase
        end

        if (load_use_stall) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            ret_q         <= RUN;
            fcnt_q        <= '0;
            wcnt_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            fcnt_q        <= fcnt_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Reset holds the front end closed and injects NOPs regardless of inputs.
    assign pc_write    = reset & pc_write_c;
    assign ifid_write  = reset & ifid_write_c;
    assign ifid_flush  = ~reset | ifid_flush_c;
    assign idex_bubble = ~reset | idex_bubble_c;
    assign pipe_stall  = reset & pipe_stall_c;
    assign fwd_a       = reset ? fwd_a_c : FWD_REG;
    assign fwd_b       = reset ? fwd_b_c : FWD_REG;
    assign ctrl_state  = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef MIPS_HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (load_use_stall && !(&stall_cnt_q))         stall_cnt_d   = stall_cnt_q + 1'b1;
        if (ifid_flush_c && !(&flush_cnt_q))           flush_cnt_d   = flush_cnt_q + 1'b1;
        if (state_q == MEM_WAIT && !(&memwait_cnt_q))  memwait_cnt_d = memwait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed checks of mips_hazard_ctrl: reset, forwarding, load-use, jump,
// multi-cycle branch flush, memory wait/timeout and priority on release.
module tb_mips_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_mem_read, mem_reg_write, wb_reg_write, ex_branch_taken, id_jump, mem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall, mem_timeout;
    logic [1:0] fwd_a, fwd_b, ctrl_state;
`ifdef MIPS_HAZ_STATS_EN
    logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mips_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_reg_write   (mem_reg_write),
        .wb_reg_write    (wb_reg_write),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_stall      (pipe_stall),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .ctrl_state      (ctrl_state),
        .mem_timeout     (mem_timeout)
`ifdef MIPS_HAZ_STATS_EN
       ,.stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .memwait_cnt     (memwait_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
        ex_branch_taken = 0; id_jump = 0; mem_busy = 0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational outputs mid-cycle, away from the rising edge.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk({tag, ".pc_write"},    32'(pc_write),    32'(exp[4]));
        chk({tag, ".ifid_write"},  32'(ifid_write),  32'(exp[3]));
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(exp[2]));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(exp[1]));
        chk({tag, ".pipe_stall"},  32'(pipe_stall),  32'(exp[0]));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        // Forwarding inputs active during reset: fwd must still read 00.
        ex_rs = 5'd13; mem_rd = 5'd13; mem_reg_write = 1'b1;
        #2;
        chk_ctl("rst", 5'b00110);
        chk("rst.fwd_a", 32'(fwd_a), 0);
        chk("rst.state", 32'(ctrl_state), 0);
        chk("rst.timeout", 32'(mem_timeout), 0);

        smp(); #1; reset = 1'b1; idle();
        nxt(); smp();
        chk_ctl("idle", 5'b11000);
        chk("idle.state", 32'(ctrl_state), 0);

        // Forwarding priority and $zero exclusion.
        ex_rs = 5'd13; ex_rt = 5'd5; mem_rd = 5'd13; wb_rd = 5'd13;
        mem_reg_write = 1; wb_reg_write = 1; #1;
        chk("fwd.mem_a", 32'(fwd_a), 2);
        chk("fwd.none_b", 32'(fwd_b), 0);
        mem_rd = 5'd0; #1;
        chk("fwd.wb_a", 32'(fwd_a), 1);
        wb_reg_write = 0; #1;
        chk("fwd.nowe_a", 32'(fwd_a), 0);
        ex_rt = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; wb_reg_write = 1; #1;
        chk("fwd.mem_b", 32'(fwd_b), 2);
        mem_reg_write = 0; #1;
        chk("fwd.wb_b", 32'(fwd_b), 1);
        ex_rs = 5'd0; wb_rd = 5'd0; mem_rd = 5'd0; mem_reg_write = 1; #1;
        chk("fwd.zero_a", 32'(fwd_a), 0);

        // Load-use on rs: one stall cycle, then the load moves on.
        nxt(); idle(); ex_mem_read = 1; ex_rd = 5'd12; id_rs = 5'd12; smp();
        chk_ctl("lu_rs", 5'b00010);
        chk("lu_rs.state", 32'(ctrl_state), 0);
        nxt(); ex_mem_read = 0; smp();
        chk_ctl("lu_after", 5'b11000);
        nxt(); idle(); ex_mem_read = 1; ex_rd = 5'd9; id_rt = 5'd9; smp();
        chk_ctl("lu_rt", 5'b00010);
        nxt(); idle(); ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0; smp();
        chk_ctl("lu_zero", 5'b11000);

        // Jump flushes IF/ID for one cycle only.
        nxt(); idle(); id_jump = 1; smp();
        chk_ctl("jump", 5'b11100);
        nxt(); id_jump = 0; smp();
        chk_ctl("jump_after", 5'b11000);
        chk("jump.state", 32'(ctrl_state), 0);

        // Taken branch with FLUSH_CYCLES=3: three consecutive flush cycles.
        nxt(); ex_branch_taken = 1; smp();
        chk_ctl("br0", 5'b11110);
        nxt(); ex_branch_taken = 0; smp();
        chk_ctl("br1", 5'b11100);
        chk("br1.state", 32'(ctrl_state), 1);
        nxt(); smp();
        chk_ctl("br2", 5'b11100);
        nxt(); smp();
        chk_ctl("br3", 5'b11000);
        chk("br3.state", 32'(ctrl_state), 0);

        // 16 busy cycles: stall throughout, timeout visible after the 15th edge.
        for (int k = 1; k <= 16; k++) begin
            nxt(); mem_busy = 1; smp();
            chk($sformatf("mw%0d.stall", k), 32'(pipe_stall), 1);
            chk($sformatf("mw%0d.pcw", k), 32'(pc_write), 0);
            chk($sformatf("mw%0d.state", k), 32'(ctrl_state), (k == 1) ? 0 : 2);
            chk($sformatf("mw%0d.tmo", k), 32'(mem_timeout), (k >= 16) ? 1 : 0);
        end
        nxt(); mem_busy = 0; smp();
        chk_ctl("mw_rel", 5'b11000);
        chk("mw_rel.state", 32'(ctrl_state), 2);
        nxt(); smp();
        chk("mw_done.state", 32'(ctrl_state), 0);
        chk("mw_done.tmo", 32'(mem_timeout), 1);

        // Branch + load-use + busy together: freeze wins, branch applied on release.
        nxt(); ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd12; id_rs = 5'd12; mem_busy = 1; smp();
        chk_ctl("pri0", 5'b00001);
        nxt(); smp();
        chk_ctl("pri1", 5'b00001);
        chk("pri1.state", 32'(ctrl_state), 2);
        nxt(); mem_busy = 0; smp();
        chk_ctl("pri_rel", 5'b11110);
        chk("pri_rel.state", 32'(ctrl_state), 2);
        nxt(); idle(); smp();
        chk("pf1.flush", 32'(ifid_flush), 1);
        chk("pf1.state", 32'(ctrl_state), 1);
        // Busy during FLUSH parks the flush count and resumes it after release.
        nxt(); mem_busy = 1; smp();
        chk("pf_busy.stall", 32'(pipe_stall), 1);
        chk("pf_busy.state", 32'(ctrl_state), 1);
        nxt(); mem_busy = 0; smp();
        chk("pf_rel.flush", 32'(ifid_flush), 1);
        chk("pf_rel.state", 32'(ctrl_state), 2);
        nxt(); smp();
        chk("pf_done.flush", 32'(ifid_flush), 0);
        chk("pf_done.state", 32'(ctrl_state), 0);

        // Asynchronous reset in the middle of MEM_WAIT.
        nxt(); mem_busy = 1;
        nxt(); smp();
        chk("ar_pre.state", 32'(ctrl_state), 2);
        #2; reset = 1'b0; #1;
        chk("ar.state", 32'(ctrl_state), 0);
        chk("ar.tmo", 32'(mem_timeout), 0);
        chk("ar.flush", 32'(ifid_flush), 1);
        chk("ar.stall", 32'(pipe_stall), 0);
        nxt(); smp(); #1; reset = 1'b1; idle();
        nxt(); smp();
        chk_ctl("ar_rel", 5'b11000);
        chk("ar_rel.state", 32'(ctrl_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
